// File: rtl/cu_multicycle_seq.sv
// -----------------------------------------------------------------------------
// cu_multicycle_seq
// Multi-cycle control sequencer for the Cortex-M0 core. It walks each
// instruction through FETCH, DECODE, EXECUTE, an optional MEM phase and WB.
// It handles memory wait states, raises a sticky bus fault when a wait
// exceeds TIMEOUT cycles, and holds in IDLE while halt is high. It also
// counts retired instructions.
//
// Ports
//   clk, rst        : clock (rising edge); asynchronous active-high reset
//   halt            : hold in IDLE (sampled in IDLE and WB only)
//   mem_rdy         : memory ready for the current FETCH/MEM request
//   ig_ex           : decoder says skip this instruction (latched in DECODE)
//   is_mem/is_store : decoder says data access needed / access is a write
//   write_rd        : decoder says write Rd
//   update_flags    : decoder says write APSR
//   br_en           : decoder says branch taken
//   cu_fetch/cu_decode/cu_execute/cu_mem : one-hot phase strobes
//   mem_req, cu_wr_mem                   : memory request / write strobe
//   ld_pc, ld_rd, ld_apsr, cu_branch     : WB register-load strobes
//   fault           : sticky bus-timeout fault
//   state           : current state code
//   ret_cnt         : retired-instruction counter (wraps)
// -----------------------------------------------------------------------------
module cu_multicycle_seq #(
   parameter int TIMEOUT = 15,
   parameter int CNT_W   = 4,
   parameter int RET_W   = 32
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             halt,
   input  logic             mem_rdy,
   input  logic             ig_ex,
   input  logic             is_mem,
   input  logic             is_store,
   input  logic             write_rd,
   input  logic             update_flags,
   input  logic             br_en,
   output logic             cu_fetch,
   output logic             cu_decode,
   output logic             cu_execute,
   output logic             cu_mem,
   output logic             mem_req,
   output logic             cu_wr_mem,
   output logic             ld_pc,
   output logic             ld_rd,
   output logic             ld_apsr,
   output logic             cu_branch,
   output logic             fault,
   output logic [2:0]       state,
   output logic [RET_W-1:0] ret_cnt
);

   localparam logic [2:0] S_IDLE    = 3'd0;
   localparam logic [2:0] S_FETCH   = 3'd1;
   localparam logic [2:0] S_DECODE  = 3'd2;
   localparam logic [2:0] S_EXECUTE = 3'd3;
   localparam logic [2:0] S_MEM     = 3'd4;
   localparam logic [2:0] S_WB      = 3'd5;
   localparam logic [2:0] S_FAULT   = 3'd7;

   // Last wait-counter value tolerated before a fault (only meaningful when enabled).
   localparam int               WAIT_LAST_I = (TIMEOUT > 0) ? (TIMEOUT - 1) : 0;
   localparam logic [CNT_W-1:0] WAIT_LAST   = CNT_W'(WAIT_LAST_I);
   localparam logic             TIMEOUT_EN  = (TIMEOUT != 0) ? 1'b1 : 1'b0;
   localparam logic [CNT_W-1:0] CNT_ZERO    = CNT_W'(1'b0);
   localparam logic [CNT_W-1:0] CNT_ONE     = CNT_W'(1'b1);
   localparam logic [RET_W-1:0] RET_ZERO    = RET_W'(1'b0);
   localparam logic [RET_W-1:0] RET_ONE     = RET_W'(1'b1);

   logic [2:0]       state_r;
   logic [2:0]       state_nxt_s;
   logic [CNT_W-1:0] wait_cnt_r;
   logic [CNT_W-1:0] wait_cnt_nxt_s;
   logic             skip_r;
   logic             skip_nxt_s;
   logic [RET_W-1:0] ret_cnt_r;
   logic             fault_r;
   logic             wait_expired_s;
   logic             in_wb_s;

   // Timeout reached: this wait cycle is the last one tolerated.
   assign wait_expired_s = TIMEOUT_EN & (wait_cnt_r == WAIT_LAST);

   // Next-state, wait counter and skip-flag logic.
   always_comb begin
      state_nxt_s    = state_r;
      wait_cnt_nxt_s = CNT_ZERO;
      skip_nxt_s     = skip_r;
      case (state_r)
         S_IDLE: begin
            if (!halt) begin
               state_nxt_s = S_FETCH;
            end else begin
               state_nxt_s = S_IDLE;
            end
         end
         S_FETCH, S_MEM: begin
            // Ready wins over a timeout reached in the same cycle.
            if (mem_rdy) begin
               state_nxt_s = (state_r == S_FETCH) ? S_DECODE : S_WB;
            end else if (wait_expired_s) begin
               state_nxt_s = S_FAULT;
            end else begin
               state_nxt_s    = state_r;
               wait_cnt_nxt_s = wait_cnt_r + CNT_ONE;
            end
         end
         S_DECODE: begin
            skip_nxt_s = ig_ex;
            if (ig_ex) begin
               state_nxt_s = S_WB;
            end else begin
               state_nxt_s = S_EXECUTE;
            end
         end
         S_EXECUTE: begin
            if (is_mem) begin
               state_nxt_s = S_MEM;
            end else begin
               state_nxt_s = S_WB;
            end
         end
         S_WB: begin
            if (halt) begin
               state_nxt_s = S_IDLE;
            end else begin
               state_nxt_s = S_FETCH;
            end
         end
         S_FAULT: begin
            state_nxt_s = S_FAULT;
         end
         default: begin
            state_nxt_s = S_IDLE;
         end
      endcase
   end

   // State, counters and sticky fault registers.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_r    <= S_IDLE;
         wait_cnt_r <= CNT_ZERO;
         skip_r     <= 1'b0;
         ret_cnt_r  <= RET_ZERO;
         fault_r    <= 1'b0;
      end else begin
         state_r    <= state_nxt_s;
         wait_cnt_r <= wait_cnt_nxt_s;
         skip_r     <= skip_nxt_s;
         if (state_r == S_WB) begin
            ret_cnt_r <= ret_cnt_r + RET_ONE;
         end
         if (state_nxt_s == S_FAULT) begin
            fault_r <= 1'b1;
         end
      end
   end

   assign in_wb_s    = (state_r == S_WB);

   // Strobes decode directly from the current state so they vanish the
   // instant an asynchronous reset forces IDLE.
   assign cu_fetch   = (state_r == S_FETCH);
   assign cu_decode  = (state_r == S_DECODE);
   assign cu_execute = (state_r == S_EXECUTE);
   assign cu_mem     = (state_r == S_MEM);
   assign mem_req    = cu_fetch | cu_mem;
   assign cu_wr_mem  = cu_mem & is_store;

   // A store never writes Rd; a skipped instruction only advances the PC.
   assign ld_pc      = in_wb_s;
   assign ld_rd      = in_wb_s & write_rd & ~skip_r & ~(is_mem & is_store);
   assign ld_apsr    = in_wb_s & update_flags & ~skip_r;
   assign cu_branch  = in_wb_s & br_en & ~skip_r;

   assign fault      = fault_r;
   assign state      = state_r;
   assign ret_cnt    = ret_cnt_r;

endmodule

// File: tb/tb_cu_multicycle_seq.sv
// -----------------------------------------------------------------------------
// tb_cu_multicycle_seq
// Self-checking bench for cu_multicycle_seq. It runs three parts:
//   - a directed vector table (ALU op, load with waits, store, skip, halt);
//   - randomized instruction streams, expanded into expected per-cycle
//     behaviour by an instruction-level model;
//   - hand-written sequences for the timeout fault, ready on the last
//     tolerated wait, and asynchronous reset during MEM.
// -----------------------------------------------------------------------------
module tb_cu_multicycle_seq;

   localparam int TIMEOUT = 15;
   localparam int CNT_W   = 4;
   localparam int RET_W   = 32;

   localparam logic [2:0] S_IDLE = 3'd0, S_FETCH = 3'd1, S_DECODE = 3'd2,
                          S_EXECUTE = 3'd3, S_MEM = 3'd4, S_WB = 3'd5, S_FAULT = 3'd7;

   // Output bit order: fetch,decode,execute,mem,mem_req,wr_mem,ld_pc,ld_rd,ld_apsr,branch,fault
   localparam logic [10:0] O_IDLE    = 11'b00000000000;
   localparam logic [10:0] O_FETCH   = 11'b10001000000;
   localparam logic [10:0] O_DEC     = 11'b01000000000;
   localparam logic [10:0] O_EXE     = 11'b00100000000;
   localparam logic [10:0] O_MEM_LD  = 11'b00011000000;
   localparam logic [10:0] O_MEM_ST  = 11'b00011100000;
   localparam logic [10:0] O_WB_ALU  = 11'b00000011100;
   localparam logic [10:0] O_WB_LD   = 11'b00000011000;
   localparam logic [10:0] O_WB_PC   = 11'b00000010000;
   localparam logic [10:0] O_FAULT   = 11'b00000000001;

   logic clk = 1'b0;
   logic rst = 1'b1;
   logic halt = 1'b0, mem_rdy = 1'b0, ig_ex = 1'b0, is_mem = 1'b0;
   logic is_store = 1'b0, write_rd = 1'b0, update_flags = 1'b0, br_en = 1'b0;
   logic cu_fetch, cu_decode, cu_execute, cu_mem, mem_req, cu_wr_mem;
   logic ld_pc, ld_rd, ld_apsr, cu_branch, fault;
   logic [2:0]       state;
   logic [RET_W-1:0] ret_cnt;
   logic [10:0]      obs;

   int checks   = 0;
   int failures = 0;

   typedef struct {
      logic halt, rdy, ig, ism, iss, wr, uf, br;
      logic [2:0]  st;
      logic [10:0] out;
      logic [31:0] ret;
   } vec_t;

   vec_t tbl [28];
   vec_t rq  [$];

   cu_multicycle_seq #(.TIMEOUT(TIMEOUT), .CNT_W(CNT_W), .RET_W(RET_W)) dut (
      .clk(clk), .rst(rst), .halt(halt), .mem_rdy(mem_rdy), .ig_ex(ig_ex),
      .is_mem(is_mem), .is_store(is_store), .write_rd(write_rd),
      .update_flags(update_flags), .br_en(br_en),
      .cu_fetch(cu_fetch), .cu_decode(cu_decode), .cu_execute(cu_execute),
      .cu_mem(cu_mem), .mem_req(mem_req), .cu_wr_mem(cu_wr_mem),
      .ld_pc(ld_pc), .ld_rd(ld_rd), .ld_apsr(ld_apsr), .cu_branch(cu_branch),
      .fault(fault), .state(state), .ret_cnt(ret_cnt)
   );

   assign obs = {cu_fetch, cu_decode, cu_execute, cu_mem, mem_req, cu_wr_mem,
                 ld_pc, ld_rd, ld_apsr, cu_branch, fault};

   always #5 clk = ~clk;

   function automatic vec_t mk(input logic h, input logic r, input logic ig,
                               input logic m, input logic s, input logic w,
                               input logic u, input logic b, input logic [2:0] st,
                               input logic [10:0] o, input logic [31:0] rc);
      vec_t v;
      v.halt = h; v.rdy = r; v.ig = ig; v.ism = m; v.iss = s;
      v.wr = w; v.uf = u; v.br = b; v.st = st; v.out = o; v.ret = rc;
      return v;
   endfunction

   // Strobe rules of each phase, straight from the phase definitions.
   function automatic logic [10:0] phase_out(input logic [2:0] st, input logic ism,
                                             input logic iss, input logic wr,
                                             input logic uf, input logic br,
                                             input logic skip);
      logic [10:0] o;
      o = O_IDLE;
      if (st == S_FETCH)   o = O_FETCH;
      if (st == S_DECODE)  o = O_DEC;
      if (st == S_EXECUTE) o = O_EXE;
      if (st == S_MEM)     o = iss ? O_MEM_ST : O_MEM_LD;
      if (st == S_WB) begin
         o[4] = 1'b1;
         o[3] = wr & ~skip & ~(ism & iss);
         o[2] = uf & ~skip;
         o[1] = br & ~skip;
      end
      if (st == S_FAULT)   o = O_FAULT;
      return o;
   endfunction

   task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=0x%0h expected=0x%0h", tag, act, exp);
      end
   endtask

   task automatic drive(input vec_t v);
      halt = v.halt; mem_rdy = v.rdy; ig_ex = v.ig; is_mem = v.ism;
      is_store = v.iss; write_rd = v.wr; update_flags = v.uf; br_en = v.br;
   endtask

   // Drive a cycle's inputs, compare at the falling edge, advance one cycle.
   task automatic apply(input vec_t v, input string tag, input int idx);
      drive(v);
      @(negedge clk);
      check($sformatf("%s[%0d].state", tag, idx), {29'd0, state}, {29'd0, v.st});
      check($sformatf("%s[%0d].strobes", tag, idx), {21'd0, obs}, {21'd0, v.out});
      check($sformatf("%s[%0d].ret_cnt", tag, idx), ret_cnt, v.ret);
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rst = 1'b1;
      drive(mk(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, S_IDLE, O_IDLE, 32'd0));
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b0;
   endtask

   function automatic logic rb();
      return 1'($urandom_range(0, 1));
   endfunction

   // Expand n random instructions into expected per-cycle records.
   task automatic gen_random(input int n);
      int  ret, wf, wm, h;
      logic ig, ism, iss, wr, uf, br;
      ret = 0;
      rq.delete();
      rq.push_back(mk(1'b0, rb(), rb(), rb(), rb(), rb(), rb(), rb(), S_IDLE, O_IDLE, 32'(ret)));
      for (int k = 0; k < n; k++) begin
         wf  = ($urandom_range(0, 3) == 0) ? $urandom_range(0, TIMEOUT - 1) : $urandom_range(0, 2);
         wm  = ($urandom_range(0, 3) == 0) ? $urandom_range(0, TIMEOUT - 1) : $urandom_range(0, 2);
         h   = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 4) : 0;
         ig  = ($urandom_range(0, 3) == 0);
         ism = rb(); iss = rb(); wr = rb(); uf = rb(); br = rb();
         for (int i = 0; i < wf; i++)
            rq.push_back(mk(rb(), 1'b0, rb(), rb(), rb(), rb(), rb(), rb(), S_FETCH, O_FETCH, 32'(ret)));
         rq.push_back(mk(rb(), 1'b1, rb(), rb(), rb(), rb(), rb(), rb(), S_FETCH, O_FETCH, 32'(ret)));
         rq.push_back(mk(rb(), rb(), ig, ism, iss, wr, uf, br, S_DECODE, O_DEC, 32'(ret)));
         if (!ig) begin
            rq.push_back(mk(rb(), rb(), ig, ism, iss, wr, uf, br, S_EXECUTE, O_EXE, 32'(ret)));
            if (ism) begin
               for (int i = 0; i < wm; i++)
                  rq.push_back(mk(rb(), 1'b0, ig, ism, iss, wr, uf, br, S_MEM,
                                  phase_out(S_MEM, ism, iss, wr, uf, br, ig), 32'(ret)));
               rq.push_back(mk(rb(), 1'b1, ig, ism, iss, wr, uf, br, S_MEM,
                               phase_out(S_MEM, ism, iss, wr, uf, br, ig), 32'(ret)));
            end
         end
         rq.push_back(mk(h > 0, rb(), ig, ism, iss, wr, uf, br, S_WB,
                         phase_out(S_WB, ism, iss, wr, uf, br, ig), 32'(ret)));
         ret++;
         if (h > 0) begin
            for (int i = 0; i < h - 1; i++)
               rq.push_back(mk(1'b1, rb(), rb(), rb(), rb(), rb(), rb(), rb(), S_IDLE, O_IDLE, 32'(ret)));
            rq.push_back(mk(1'b0, rb(), rb(), rb(), rb(), rb(), rb(), rb(), S_IDLE, O_IDLE, 32'(ret)));
         end
      end
   endtask

   initial begin
      // Directed table: ALU op, load with 3 waits, store, skipped branch, halt hold.
      tbl[0]  = mk(0,0,0,0,0,0,0,0, S_IDLE,    O_IDLE,   32'd0);
      tbl[1]  = mk(0,1,0,0,0,0,0,0, S_FETCH,   O_FETCH,  32'd0);
      tbl[2]  = mk(0,0,0,0,0,1,1,0, S_DECODE,  O_DEC,    32'd0);
      tbl[3]  = mk(0,0,0,0,0,1,1,0, S_EXECUTE, O_EXE,    32'd0);
      tbl[4]  = mk(0,0,0,0,0,1,1,0, S_WB,      O_WB_ALU, 32'd0);
      tbl[5]  = mk(0,1,0,0,0,0,0,0, S_FETCH,   O_FETCH,  32'd1);
      tbl[6]  = mk(0,0,0,1,0,1,0,0, S_DECODE,  O_DEC,    32'd1);
      tbl[7]  = mk(0,0,0,1,0,1,0,0, S_EXECUTE, O_EXE,    32'd1);
      tbl[8]  = mk(0,0,0,1,0,1,0,0, S_MEM,     O_MEM_LD, 32'd1);
      tbl[9]  = mk(0,0,0,1,0,1,0,0, S_MEM,     O_MEM_LD, 32'd1);
      tbl[10] = mk(0,0,0,1,0,1,0,0, S_MEM,     O_MEM_LD, 32'd1);
      tbl[11] = mk(0,1,0,1,0,1,0,0, S_MEM,     O_MEM_LD, 32'd1);
      tbl[12] = mk(0,0,0,1,0,1,0,0, S_WB,      O_WB_LD,  32'd1);
      tbl[13] = mk(0,0,0,0,0,0,0,0, S_FETCH,   O_FETCH,  32'd2);
      tbl[14] = mk(0,1,0,0,0,0,0,0, S_FETCH,   O_FETCH,  32'd2);
      tbl[15] = mk(0,0,0,1,1,1,0,0, S_DECODE,  O_DEC,    32'd2);
      tbl[16] = mk(0,0,0,1,1,1,0,0, S_EXECUTE, O_EXE,    32'd2);
      tbl[17] = mk(0,1,0,1,1,1,0,0, S_MEM,     O_MEM_ST, 32'd2);
      tbl[18] = mk(0,0,0,1,1,1,0,0, S_WB,      O_WB_PC,  32'd2);
      tbl[19] = mk(0,1,0,0,0,0,0,0, S_FETCH,   O_FETCH,  32'd3);
      tbl[20] = mk(0,0,1,0,0,1,1,1, S_DECODE,  O_DEC,    32'd3);
      tbl[21] = mk(1,0,1,0,0,1,1,1, S_WB,      O_WB_PC,  32'd3);
      tbl[22] = mk(1,0,0,0,0,0,0,0, S_IDLE,    O_IDLE,   32'd4);
      tbl[23] = mk(1,0,0,0,0,0,0,0, S_IDLE,    O_IDLE,   32'd4);
      tbl[24] = mk(1,0,0,0,0,0,0,0, S_IDLE,    O_IDLE,   32'd4);
      tbl[25] = mk(1,0,0,0,0,0,0,0, S_IDLE,    O_IDLE,   32'd4);
      tbl[26] = mk(0,0,0,0,0,0,0,0, S_IDLE,    O_IDLE,   32'd4);
      tbl[27] = mk(0,1,0,0,0,0,0,0, S_FETCH,   O_FETCH,  32'd4);

      do_reset();
      for (int i = 0; i < 28; i++) apply(tbl[i], "table", i);

      // Randomized instruction streams against the instruction-level model.
      for (int pass = 0; pass < 2; pass++) begin
         do_reset();
         gen_random(30);
         for (int i = 0; i < rq.size(); i++) apply(rq[i], $sformatf("rand%0d", pass), i);
      end

      // Timeout: 15 wait cycles in FETCH, then FAULT held regardless of inputs.
      do_reset();
      apply(mk(0,0,0,0,0,0,0,0, S_IDLE, O_IDLE, 32'd0), "tmo", 0);
      for (int i = 0; i < TIMEOUT; i++)
         apply(mk(0,0,0,0,0,0,0,0, S_FETCH, O_FETCH, 32'd0), "tmo_wait", i);
      for (int i = 0; i < 4; i++)
         apply(mk(1'(i % 2),1,0,1,1,1,1,1, S_FAULT, O_FAULT, 32'd0), "tmo_fault", i);
      do_reset();
      apply(mk(1,0,0,0,0,0,0,0, S_IDLE, O_IDLE, 32'd0), "tmo_cleared", 0);

      // Ready on the 15th wait cycle wins over the timeout.
      do_reset();
      apply(mk(0,0,0,0,0,0,0,0, S_IDLE, O_IDLE, 32'd0), "rdy15", 0);
      for (int i = 0; i < TIMEOUT - 1; i++)
         apply(mk(0,0,0,0,0,0,0,0, S_FETCH, O_FETCH, 32'd0), "rdy15_wait", i);
      apply(mk(0,1,0,0,0,0,0,0, S_FETCH, O_FETCH, 32'd0), "rdy15_last", 0);
      apply(mk(0,0,0,0,0,1,0,0, S_DECODE, O_DEC, 32'd0), "rdy15_dec", 0);

      // Asynchronous reset in the middle of a MEM wait.
      do_reset();
      apply(mk(0,0,0,0,0,0,0,0, S_IDLE,    O_IDLE,   32'd0), "arst", 0);
      apply(mk(0,1,0,0,0,0,0,0, S_FETCH,   O_FETCH,  32'd0), "arst", 1);
      apply(mk(0,0,0,0,0,1,0,0, S_DECODE,  O_DEC,    32'd0), "arst", 2);
      apply(mk(0,0,0,0,0,1,0,0, S_EXECUTE, O_EXE,    32'd0), "arst", 3);
      apply(mk(0,0,0,0,0,1,0,0, S_WB,      O_WB_LD,  32'd0), "arst", 4);
      apply(mk(0,1,0,0,0,0,0,0, S_FETCH,   O_FETCH,  32'd1), "arst", 5);
      apply(mk(0,0,0,1,0,1,0,0, S_DECODE,  O_DEC,    32'd1), "arst", 6);
      apply(mk(0,0,0,1,0,1,0,0, S_EXECUTE, O_EXE,    32'd1), "arst", 7);
      apply(mk(0,0,0,1,0,1,0,0, S_MEM,     O_MEM_LD, 32'd1), "arst", 8);
      #1;
      check("arst.pre_state", {29'd0, state}, {29'd0, S_MEM});
      rst = 1'b1;
      #1;
      check("arst.state", {29'd0, state}, {29'd0, S_IDLE});
      check("arst.ret_cnt", ret_cnt, 32'd0);
      check("arst.strobes", {21'd0, obs}, {21'd0, O_IDLE});
      @(posedge clk);
      #1;
      rst = 1'b0;

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/cu_multicycle_seq.md
Name: cu_multicycle_seq

Overview:
- Parametrised multi-cycle control sequencer for the Cortex-M0 core; successor to the 4-state fetch/decode/execute control FSM.
- Adds memory handshake with wait states for fetch and load/store, and a dedicated memory phase.
- Adds a wait-state timeout that raises a sticky bus fault, a halt hold in IDLE, and a retired-instruction counter.
- Drives the phase strobes and register-load enables for PC, Rd, APSR and branch.

Parameters:
- TIMEOUT, 15: maximum consecutive wait cycles tolerated in FETCH or MEM before FAULT; 0 disables the timeout.
- CNT_W, 4: width of the wait counter; TIMEOUT < 2^CNT_W is required.
- RET_W, 32: width of the retired-instruction counter.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  reset, asynchronous, active-high.
- halt  in  1  hold in IDLE while high.
- mem_rdy  in  1  memory ready/ack for the current request.
- ig_ex  in  1  from decoder, sampled in DECODE: skip execution of this instruction.
- is_mem  in  1  from decoder: instruction needs a data memory access.
- is_store  in  1  from decoder: the data access is a write.
- write_rd  in  1  from decoder: write the result to Rd.
- update_flags  in  1  from decoder: write APSR.
- br_en  in  1  from decoder: branch taken.
- cu_fetch  out  1  high in FETCH.
- cu_decode  out  1  high in DECODE.
- cu_execute  out  1  high in EXECUTE.
- cu_mem  out  1  high in MEM.
- mem_req  out  1  high in FETCH and MEM.
- cu_wr_mem  out  1  high in MEM when is_store = 1.
- ld_pc  out  1  PC load strobe.
- ld_rd  out  1  Rd load strobe.
- ld_apsr  out  1  APSR load strobe.
- cu_branch  out  1  branch strobe.
- fault  out  1  sticky bus-timeout fault.
- state  out  3  current state code.
- ret_cnt  out  RET_W  count of retired instructions.

Behaviour:
- State encoding: IDLE=0, FETCH=1, DECODE=2, EXECUTE=3, MEM=4, WB=5, FAULT=7. Code 6 is unused and returns to IDLE.
- Reset (async): state=IDLE, wait_cnt=0, skip=0, ret_cnt=0, fault=0. All strobes are combinational from state and are therefore 0 in IDLE.
- IDLE: go to FETCH when halt=0; otherwise stay in IDLE.
- FETCH: mem_req=1.
  - mem_rdy=1 → DECODE, wait_cnt←0.
  - mem_rdy=0 → stay, wait_cnt+1.
  - mem_rdy=0 with wait_cnt == TIMEOUT-1 and TIMEOUT≠0 → FAULT.
- DECODE: skip←ig_ex; wait_cnt←0.
  - ig_ex=1 → WB.
  - ig_ex=0 → EXECUTE.
- EXECUTE: is_mem=1 → MEM; is_mem=0 → WB.
- MEM: mem_req=1; cu_wr_mem=is_store. mem_rdy and timeout handling are identical to FETCH; on mem_rdy=1 the next state is WB.
- WB, lasting one cycle:
  - ld_pc=1.
  - ld_rd = write_rd & !skip & !(is_mem & is_store).
  - ld_apsr = update_flags & !skip.
  - cu_branch = br_en & !skip.
  - ret_cnt+1, wrapping modulo 2^RET_W.
  - Next state: IDLE if halt=1, else FETCH.
- FAULT: fault=1; all strobes 0; state is held until rst. halt is ignored in FAULT.
- Timing:
  - Minimum latency is 4 cycles/instruction (FETCH, DECODE, EXECUTE, WB), or 5 with MEM.
  - Each wait cycle adds 1.
  - A skipped instruction takes 3 cycles.
- Decoder inputs must be stable from DECODE through WB. Only ig_ex is latched (into skip).
- mem_rdy is ignored outside FETCH and MEM.
- If mem_rdy=1 on the same cycle the timeout is reached, ready wins and there is no fault.
- halt is sampled only in IDLE and WB; an in-flight instruction always completes.
- rst asserted mid-instruction returns to IDLE immediately, with no strobes and ret_cnt cleared.
- Exactly one of cu_fetch/cu_decode/cu_execute/cu_mem is high, or none in IDLE/WB/FAULT.

Test Plan:
- ALU op, mem_rdy=1 always, write_rd=1, update_flags=1 → states 1,2,3,5. ld_rd, ld_apsr and ld_pc pulse together in cycle 4; ret_cnt=1.
- Load: is_mem=1, is_store=0, mem_rdy low 3 cycles in MEM → MEM lasts 4 cycles; cu_wr_mem=0; ld_rd pulses in WB; total 8 cycles.
- Store: is_mem=1, is_store=1, write_rd=1 → cu_wr_mem=1 during MEM; ld_rd=0 in WB.
- ig_ex=1 with br_en=1 and write_rd=1 → DECODE goes to WB; only ld_pc pulses; cu_branch=0; ret_cnt increments.
- TIMEOUT=15, mem_rdy held 0 in FETCH:
  - → FAULT entered after 15 wait cycles; fault=1 is held; strobes 0 until rst.
  - Repeat with mem_rdy=1 on the 15th cycle → no fault, DECODE.
- halt=1 at WB, then released after 5 cycles → IDLE held 5 cycles, then FETCH.
- rst pulse during MEM → state=0 and ret_cnt=0 immediately, asynchronously.
